// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared types and constants for the CIC interpolator
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int OS_MIN = 1;
  localparam int OS_MAX = 6;
  localparam int GUARD  = 8;

  // Ratio codes 1..6 select R=2..64; everything else disables the block.
  function automatic logic os_valid(input logic [2:0] os);
    return (os >= 3'(OS_MIN)) && (os <= 3'(OS_MAX));
  endfunction

endpackage

// File: rtl/cic_diff.sv
// rtl/cic_diff.sv - registered first-difference (comb) stage with enable
module cic_diff #(
  parameter int W = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                take_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [W-1:0] diff_o
);

  logic signed [W-1:0] prev_q;
  logic signed [W-1:0] diff_q;
  logic signed [W-1:0] cur;

  // When take_i is low the stage re-consumes its previous input (hold-repeat).
  assign cur = take_i ? d_i : prev_q;

  // Advance the difference only on enabled slots; flush clears the history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      diff_q <= '0;
    end else if (clr_i) begin
      prev_q <= '0;
      diff_q <= '0;
    end else if (en_i) begin
      prev_q <= cur;
      diff_q <= cur - prev_q;
    end
  end

  assign diff_o = diff_q;

endmodule

// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - two-stage CIC interpolator, R = 2^os_sel
module cic_interp
  import cic_pkg::*;
#(
  parameter int IDW = 16,
  parameter int ODW = 16
) (
  input  logic                  clk_div,
  input  logic                  reset_n,
  input  logic [2:0]            os_sel,
  input  logic signed [IDW-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic signed [ODW-1:0] data_out,
  output logic                  out_valid,
  output logic                  underrun
);

  localparam int IW = IDW + GUARD;
  localparam logic signed [IW-1:0] OMAX = {{(IW-ODW+1){1'b0}}, {(ODW-1){1'b1}}};
  localparam logic signed [IW-1:0] OMIN = {{(IW-ODW+1){1'b1}}, {(ODW-1){1'b0}}};

  state_e              state_q, state_d;
  logic [5:0]          phase_q, phase_d;
  logic [2:0]          os_sel_q;
  logic [6:0]          r_full;
  logic [5:0]          phase_last;
  logic                consume;
  logic                clr;
  logic                tag1_q, tag2_q;
  logic signed [IW-1:0] x_new, c1, c2;
  logic signed [IW-1:0] i1_q, i2_q;
  logic signed [IW-1:0] shifted;
  logic signed [ODW-1:0] sat;
  logic signed [ODW-1:0] data_out_q;
  logic                started_q, out_valid_q, underrun_q;
  logic [2:0]          vpipe_q;

  assign r_full     = 7'd1 << os_sel_q;
  assign phase_last = 6'(r_full - 7'd1);
  assign x_new      = {{GUARD{data_in[IDW-1]}}, data_in};
  assign in_ready   = (state_q == WAIT) || ((state_q == RUN) && (phase_q == 6'd0));

  // Next state, phase and consume strobe; a bad or changed ratio forces a flush.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = WAIT;
        phase_d = 6'd0;
      end
      WAIT: begin
        if (in_valid) begin
          state_d = RUN;
          phase_d = 6'd1;
          consume = 1'b1;
        end
      end
      RUN: begin
        consume = (phase_q == 6'd0);
        phase_d = (phase_q == phase_last) ? 6'd0 : phase_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase
    if (!os_valid(os_sel) || (os_sel != os_sel_q)) begin
      state_d = IDLE;
      phase_d = 6'd0;
    end
  end

  assign clr = (state_q == IDLE) || (state_d == IDLE);

  // State, phase and ratio registers.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= 6'd0;
      os_sel_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      os_sel_q <= os_sel;
    end
  end

  cic_diff #(.W(IW)) u_s1 (
    .clk_i  (clk_div),
    .rst_ni (reset_n),
    .clr_i  (clr),
    .en_i   (consume),
    .take_i (in_valid),
    .d_i    (x_new),
    .diff_o (c1)
  );

  cic_diff #(.W(IW)) u_s2 (
    .clk_i  (clk_div),
    .rst_ni (reset_n),
    .clr_i  (clr),
    .en_i   (tag1_q),
    .take_i (1'b1),
    .d_i    (c1),
    .diff_o (c2)
  );

  // Consume tags travel alongside the comb; integrators zero-stuff between tags.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      tag1_q <= 1'b0;
      tag2_q <= 1'b0;
      i1_q   <= '0;
      i2_q   <= '0;
    end else if (clr) begin
      tag1_q <= 1'b0;
      tag2_q <= 1'b0;
      i1_q   <= '0;
      i2_q   <= '0;
    end else begin
      tag1_q <= consume;
      tag2_q <= tag1_q;
      if (state_q == RUN) begin
        i1_q <= i1_q + (tag2_q ? c2 : {IW{1'b0}});
        i2_q <= i2_q + i1_q;
      end
    end
  end

  // Remove gain R by arithmetic shift, then clamp into the output width.
  always_comb begin
    shifted = i2_q >>> os_sel_q;
    sat     = shifted[ODW-1:0];
    if (shifted > OMAX) begin
      sat = OMAX[ODW-1:0];
    end else if (shifted < OMIN) begin
      sat = OMIN[ODW-1:0];
    end
  end

  // Output register, valid delay line and sticky underrun flag.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q  <= '0;
      started_q   <= 1'b0;
      vpipe_q     <= 3'd0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else if (clr) begin
      data_out_q  <= '0;
      started_q   <= 1'b0;
      vpipe_q     <= 3'd0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      data_out_q  <= sat;
      started_q   <= started_q | consume;
      vpipe_q     <= {vpipe_q[1:0], started_q};
      out_valid_q <= vpipe_q[2];
      if ((state_q == RUN) && (phase_q == 6'd0) && !in_valid) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule
